// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART receiver types, default rates and ASCII constants.
//            Optional parity state enabled by macro UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int c_clk_freq_default = 100_000_000;
  localparam int c_baud_default     = 9600;

  // Characters recognised by the downstream matcher
  localparam logic [7:0] c_ascii_h = 8'h48;
  localparam logic [7:0] c_ascii_i = 8'h49;
  localparam logic [7:0] c_ascii_t = 8'h54;
  localparam logic [7:0] c_ascii_s = 8'h53;
  localparam logic [7:0] c_ascii_z = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_cnt
// Purpose  : Bit-period counter with synchronous clear and half/full flags.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_cnt #(
  parameter int BIT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic half,
  output logic full
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] c_half = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] c_full = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Restarts on its own at the full-bit terminal so consecutive bits stay aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear || full) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign half = (r_cnt == c_half);
  assign full = (r_cnt == c_full);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8-bit asynchronous serial receiver (8N1, or 8E1 when
//            UART_RX_PARITY_EN is defined) with valid/frame_err strobes.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = c_clk_freq_default,
  parameter int BAUD     = c_baud_default
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       valid,
  output logic [7:0] data_out,
  output logic       frame_err,
  output logic       busy
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;

  uart_state_t r_state, w_state_next;

  logic       r_rx_meta, r_rx_sync;
  logic [7:0] r_shift;
  logic [2:0] r_bit_idx;
  logic [7:0] r_data;
  logic       r_valid, r_ferr;

  logic w_cnt_clear, w_half, w_full;
  logic w_shift_en, w_valid_set, w_ferr_set;
`ifdef UART_RX_PARITY_EN
  logic r_par_err, w_par_sample;
`endif

  // Line idles high, so the synchronizer resets to 1 to avoid a false start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  uart_baud_cnt #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_baud_cnt (
    .clk  (clk),
    .rst  (rst),
    .clear(w_cnt_clear),
    .half (w_half),
    .full (w_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_clear  = 1'b0;
    w_shift_en   = 1'b0;
    w_valid_set  = 1'b0;
    w_ferr_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_sample = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        w_cnt_clear = 1'b1;
        if (!r_rx_sync) w_state_next = ST_START;
      end
      ST_START: begin
        if (w_half) begin
          w_cnt_clear  = 1'b1;
          w_state_next = r_rx_sync ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_full) begin
          w_shift_en = 1'b1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = ST_PARITY;
`else
            w_state_next = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_full) begin
          w_par_sample = 1'b1;
          w_state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_full) begin
          if (r_rx_sync) begin
`ifdef UART_RX_PARITY_EN
            w_valid_set = !r_par_err;
            w_ferr_set  = r_par_err;
`else
            w_valid_set = 1'b1;
`endif
            w_state_next = ST_IDLE;
          end else begin
            w_ferr_set   = 1'b1;
            w_state_next = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        w_cnt_clear = 1'b1;
        if (r_rx_sync) w_state_next = ST_IDLE;
      end
      default: begin
        w_cnt_clear  = 1'b1;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= 8'h00;
      r_bit_idx <= 3'd0;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_valid <= w_valid_set;
      r_ferr  <= w_ferr_set;
      if (w_valid_set) r_data <= r_shift;
      if (w_shift_en) r_shift <= {r_rx_sync, r_shift[7:1]};
      if (r_state == ST_START) begin
        r_bit_idx <= 3'd0;
      end else if (w_shift_en) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits XOR parity bit must be zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_err <= 1'b0;
    end else if (w_par_sample) begin
      r_par_err <= even_parity(r_shift) ^ r_rx_sync;
    end
  end
`endif

  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign data_out  = r_data;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed self-checking bench for uart_rx at 16 clocks per bit.
//            Exercises parity frames when UART_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int BITC = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       valid;
  logic [7:0] data_out;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int last_valid_cyc = 0;
  logic [7:0] rx_q[$];

  uart_rx #(
    .CLK_FREQ(1600),
    .BAUD    (100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .valid    (valid),
    .data_out (data_out),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      rx_q.push_back(data_out);
    end
    if (frame_err) ferr_cnt++;
    if (valid && frame_err) both_cnt++;
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BITC) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BITC) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_out); end
    rst = 1'b0;
    idle_bits(1);
  endtask

  task automatic test_single();
    int v0, f0, t0;
    v0 = valid_cnt; f0 = ferr_cnt;
    t0 = cyc;
    send_frame(8'h53, 1'b1);
    idle_bits(1);
    checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL single_valid_count got=%0d exp=1", valid_cnt - v0); end
    checks++; if (data_out !== 8'h53) begin failures++; $display("FAIL single_data got=%h exp=53", data_out); end
    checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL single_ferr_count got=%0d exp=0", ferr_cnt - f0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%b exp=0", busy); end
    // Mid-stop sample is 9.5 bits (152 cycles) after the start edge, plus sync delay
    checks++;
    if ((last_valid_cyc - t0) < 150 || (last_valid_cyc - t0) > 160) begin
      failures++; $display("FAIL single_latency got=%0d exp=150..160", last_valid_cyc - t0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [5];
    int v0, f0, q0;
    msg[0] = 8'h48; msg[1] = 8'h49; msg[2] = 8'h54; msg[3] = 8'h53; msg[4] = 8'h5A;
    v0 = valid_cnt; f0 = ferr_cnt; q0 = rx_q.size();
    for (int i = 0; i < 5; i++) send_frame(msg[i], 1'b1);
    idle_bits(1);
    checks++; if (valid_cnt - v0 !== 5) begin failures++; $display("FAIL b2b_valid_count got=%0d exp=5", valid_cnt - v0); end
    checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL b2b_ferr_count got=%0d exp=0", ferr_cnt - f0); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rx_q.size() <= q0 + i) begin
        failures++; $display("FAIL b2b_byte%0d missing exp=%h", i, msg[i]);
      end else if (rx_q[q0 + i] !== msg[i]) begin
        failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, rx_q[q0 + i], msg[i]);
      end
    end
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++; if (valid_cnt - v0 !== 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", valid_cnt - v0); end
    checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt - f0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy got=%b exp=0", busy); end
  endtask

  task automatic test_frame_err();
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(8'hA5 >> i);
`ifdef UART_RX_PARITY_EN
    send_bit(1'b0);
`endif
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ferr_wait_busy got=%b exp=1", busy); end
    idle_bits(2);
    checks++; if (ferr_cnt - f0 !== 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - f0); end
    checks++; if (valid_cnt - v0 !== 0) begin failures++; $display("FAIL ferr_valid got=%0d exp=0", valid_cnt - v0); end
    checks++; if (data_out !== 8'h5A) begin failures++; $display("FAIL ferr_data_held got=%h exp=5a", data_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_busy got=%b exp=0", busy); end
    v0 = valid_cnt;
    send_frame(8'h31, 1'b1);
    idle_bits(1);
    checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL ferr_next_count got=%0d exp=1", valid_cnt - v0); end
    checks++; if (data_out !== 8'h31) begin failures++; $display("FAIL ferr_next_data got=%h exp=31", data_out); end
  endtask

  task automatic test_reset_mid();
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    // 8'hF0: bit 4 is high, so the line is idle-level when reset releases
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rstmid_ferr got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%h exp=00", data_out); end
    rst = 1'b0;
    idle_bits(4);
    checks++;
    if ((valid_cnt - v0) !== 0 || (ferr_cnt - f0) !== 0) begin
      failures++; $display("FAIL rstmid_strobes got=%0d/%0d exp=0/0", valid_cnt - v0, ferr_cnt - f0);
    end
    send_frame(8'h54, 1'b1);
    idle_bits(1);
    checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL rstmid_next_count got=%0d exp=1", valid_cnt - v0); end
    checks++; if (data_out !== 8'h54) begin failures++; $display("FAIL rstmid_next_data got=%h exp=54", data_out); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    // 8'h53 has four ones: even parity bit is 0, so 1 is wrong
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(8'h53 >> i);
    send_bit(1'b1);
    send_bit(1'b1);
    idle_bits(1);
    checks++; if (ferr_cnt - f0 !== 1) begin failures++; $display("FAIL parity_bad_ferr got=%0d exp=1", ferr_cnt - f0); end
    checks++; if (valid_cnt - v0 !== 0) begin failures++; $display("FAIL parity_bad_valid got=%0d exp=0", valid_cnt - v0); end
    v0 = valid_cnt; f0 = ferr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(8'h53 >> i);
    send_bit(1'b0);
    send_bit(1'b1);
    idle_bits(1);
    checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL parity_good_valid got=%0d exp=1", valid_cnt - v0); end
    checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL parity_good_ferr got=%0d exp=0", ferr_cnt - f0); end
    checks++; if (data_out !== 8'h53) begin failures++; $display("FAIL parity_good_data got=%h exp=53", data_out); end
  endtask
`endif

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    checks++; if (both_cnt !== 0) begin failures++; $display("FAIL strobe_overlap got=%0d exp=0", both_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate; BIT_CYCLES = CLK_FREQ/BAUD (integer division; 10416 at defaults).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rx  input  1  asynchronous serial line, idle high, 8 data bits LSB first, 1 stop bit.
REQ-006 valid  output  1  one-cycle strobe, data_out holds a newly received byte.
REQ-007 data_out  output  8  last good received byte; held until the next valid.
REQ-008 frame_err  output  1  one-cycle strobe, stop bit sampled low.
REQ-009 busy  output  1  high whenever state is not IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer before use; all decisions use the synchronized value.
REQ-011 States SHALL be IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
REQ-012 IDLE: synchronized rx low -> START, bit counter cleared; otherwise stay.
REQ-013 START: when counter reaches BIT_CYCLES/2-1, sample; low -> DATA with counter cleared; high -> IDLE (glitch rejected, no strobe).
REQ-014 DATA: every BIT_CYCLES cycles, sample one bit into shift register LSB first; after bit index 7 -> PARITY if compiled, else STOP.
REQ-015 STOP: sample after BIT_CYCLES cycles; high -> valid=1 and data_out=shift register for exactly one cycle, next state IDLE; low -> frame_err=1 for one cycle, data_out unchanged, next state WAIT_HIGH.
REQ-016 WAIT_HIGH: stay until synchronized rx is high, then IDLE.
REQ-017 Latency: valid SHALL rise on the clock edge after the stop-bit mid-point sample, i.e. ~9.5 bit times plus 2 sync cycles after the start edge.
REQ-018 A new start edge seen in IDLE on the cycle immediately after valid SHALL be accepted (back-to-back frames, zero idle gap).
REQ-019 valid and frame_err SHALL never be high together.
REQ-020 Bit counter width SHALL be $clog2(BIT_CYCLES); counter SHALL never wrap within a bit period.

Reset
REQ-021 rst SHALL force state IDLE, synchronizer flops to 1, counters and shift register to 0.
REQ-022 Reset outputs: valid=0, data_out=8'h00, frame_err=0, busy=0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no strobe; after release, reception resumes on the next falling edge.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: frame carries an even-parity bit after bit 7, sampled in PARITY; mismatch SHALL suppress valid and assert frame_err after the stop-bit sample; frame_err also covers a low stop bit.
REQ-025 Macro undefined: PARITY state and parity logic absent, frame is 8N1.

Structure
REQ-026 Package uart_pkg SHALL hold the state enumeration, default CLK_FREQ/BAUD, and the ASCII constants used by the downstream matcher.
REQ-027 Sub-module uart_baud_cnt SHALL implement the bit-period counter (clear, half-bit and full-bit terminal flags); FSM and shift register stay in uart_rx.

Verification
REQ-028 Bench uses CLK_FREQ=1600, BAUD=100 (BIT_CYCLES=16); byte 8'h53 sent -> exactly one valid, data_out=8'h53, busy low afterward.
REQ-029 Back-to-back frames "HITSZ" (8'h48,8'h49,8'h54,8'h53,8'h5A), no idle gap -> five valid strobes in order, no frame_err.
REQ-030 rx low for 5 cycles then high -> no valid, no frame_err, returns to IDLE.
REQ-031 Byte 8'hA5 with stop bit forced low, line held low 40 cycles -> one frame_err, no valid, data_out keeps prior value, next frame 8'h31 received correctly.
REQ-032 rst pulsed during data bit 4 -> all outputs at reset values, no strobe; following frame 8'h54 received correctly.
REQ-033 With UART_RX_PARITY_EN: 8'h53 with odd parity bit -> frame_err, no valid; correct parity -> valid, data_out=8'h53.
